// File: rtl/wb_pkg.sv
// Shared definitions for the load/store Wishbone initiator.
//   size_e  : load/store access size as presented by the pipeline
//   state_e : controller states
//   sel_gen : byte-lane select for a given size and byte offset
package wb_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // Illegal size yields no lanes; such requests never reach the bus anyway.
    function automatic logic [3:0] sel_gen(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] sel;
        case (size)
            SZ_BYTE: sel = 4'b0001 << off;
            SZ_HALF: sel = off[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: sel = 4'b1111;
            default: sel = 4'b0000;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/wb_dbus_master_if.sv
// Bundle of the request, response and Wishbone data-bus signals of
// wb_dbus_master. Suffixes are from the initiator's point of view.
//   master : the initiator (wb_dbus_master)
//   slave  : the environment (pipeline + Wishbone target)
interface wb_dbus_master_if;

    logic        ls_valid_i;
    logic        ls_ready_o;
    logic        ls_we_i;
    logic [31:0] ls_addr_i;
    logic [31:0] ls_wdata_i;
    logic [1:0]  ls_size_i;
    logic        ls_unsigned_i;

    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        rsp_misaligned_o;

    logic [31:0] dwbm_addr_o;
    logic [31:0] dwbm_dat_o;
    logic [3:0]  dwbm_sel_o;
    logic        dwbm_cyc_o;
    logic        dwbm_stb_o;
    logic        dwbm_we_o;
    logic [31:0] dwbm_dat_i;
    logic        dwbm_ack_i;
    logic        dwbm_err_i;

    modport master (
        input  ls_valid_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_size_i, ls_unsigned_i,
        output ls_ready_o,
        output rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_misaligned_o,
        output dwbm_addr_o, dwbm_dat_o, dwbm_sel_o, dwbm_cyc_o, dwbm_stb_o, dwbm_we_o,
        input  dwbm_dat_i, dwbm_ack_i, dwbm_err_i
    );

    modport slave (
        output ls_valid_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_size_i, ls_unsigned_i,
        input  ls_ready_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_misaligned_o,
        input  dwbm_addr_o, dwbm_dat_o, dwbm_sel_o, dwbm_cyc_o, dwbm_stb_o, dwbm_we_o,
        output dwbm_dat_i, dwbm_ack_i, dwbm_err_i
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store path.
//   size_i, off_i   : access size and byte offset (addr[1:0])
//   uns_i           : zero-extend loads
//   wdata_i         : right-aligned store data
//   rdata_i         : raw Wishbone read word
//   sel_o, wdata_o  : byte selects and lane-replicated store data
//   rdata_o         : shifted and extended load data
//   misaligned_o    : address not aligned to size
//   illegal_o       : size encoding 11
module lsu_align
    import wb_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic        uns_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  sel_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o,
    output logic        illegal_o
);

    logic [31:0] shifted;

    assign shifted = rdata_i >> {off_i, 3'b000};
    assign sel_o   = sel_gen(size_i, off_i);

    always_comb begin
        wdata_o      = wdata_i;
        rdata_o      = shifted;
        misaligned_o = 1'b0;
        illegal_o    = 1'b0;
        case (size_i)
            SZ_BYTE: begin
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{~uns_i & shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                wdata_o      = {2{wdata_i[15:0]}};
                rdata_o      = {{16{~uns_i & shifted[15]}}, shifted[15:0]};
                misaligned_o = off_i[0];
            end
            SZ_WORD: begin
                misaligned_o = (off_i != 2'b00);
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/wb_dbus_master.sv
// Wishbone classic-cycle initiator for the core's load/store path.
// One request at a time; runs a single cyc/stb cycle with an optional
// timeout and returns a registered one-cycle response.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus           : request/response/Wishbone signals (wb_dbus_master_if.master)
// Parameters:
//   TIMEOUT   : max cycles with cyc/stb high before a timeout error; 0 disables
//   BASE_ADDR : reserved for a future address-range check
module wb_dbus_master
    import wb_pkg::*;
#(
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    wb_dbus_master_if.master  bus
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    state_e state_q, state_d;

    logic [1:0]       off_q, off_d;
    logic [1:0]       size_q, size_d;
    logic             uns_q, uns_d;
    logic             we_q, we_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0] addr_q, addr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic        cyc_q, cyc_d;
    logic        wbwe_q, wbwe_d;

    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        rsp_mis_q, rsp_mis_d;

    logic        accept;
    logic        timeout_hit;
    logic [1:0]  al_size, al_off;
    logic        al_uns;
    logic [3:0]  al_sel;
    logic [31:0] al_wdata, al_rdata;
    logic        al_mis, al_ill;

    assign accept      = bus.ls_valid_i && (state_q == ST_IDLE);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    // One aligner serves both phases: live request fields while idle
    // (lanes/selects), latched fields while on the bus (load extension).
    assign al_size = (state_q == ST_IDLE) ? bus.ls_size_i      : size_q;
    assign al_off  = (state_q == ST_IDLE) ? bus.ls_addr_i[1:0] : off_q;
    assign al_uns  = (state_q == ST_IDLE) ? bus.ls_unsigned_i  : uns_q;

    lsu_align u_align (
        .size_i       (al_size),
        .off_i        (al_off),
        .uns_i        (al_uns),
        .wdata_i      (bus.ls_wdata_i),
        .rdata_i      (bus.dwbm_dat_i),
        .sel_o        (al_sel),
        .wdata_o      (al_wdata),
        .rdata_o      (al_rdata),
        .misaligned_o (al_mis),
        .illegal_o    (al_ill)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = (al_mis || al_ill) ? ST_RESP : ST_BUS;
            ST_BUS:  if (bus.dwbm_err_i || bus.dwbm_ack_i || timeout_hit) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values for the registered outputs. Response fields default to
    // zero so they are only non-zero during the single RESP cycle.
    always_comb begin
        off_d       = off_q;
        size_d      = size_q;
        uns_d       = uns_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        cyc_d       = cyc_q;
        wbwe_d      = wbwe_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        rsp_mis_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    off_d  = bus.ls_addr_i[1:0];
                    size_d = bus.ls_size_i;
                    uns_d  = bus.ls_unsigned_i;
                    we_d   = bus.ls_we_i;
                    if (al_mis) begin
                        rsp_valid_d = 1'b1;
                        rsp_mis_d   = 1'b1;
                    end else if (al_ill) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        addr_d = {bus.ls_addr_i[31:2], 2'b00};
                        dat_d  = al_wdata;
                        sel_d  = al_sel;
                        wbwe_d = bus.ls_we_i;
                        cyc_d  = 1'b1;
                        cnt_d  = '0;
                    end
                end
            end
            ST_BUS: begin
                if (bus.dwbm_err_i) begin
                    cyc_d       = 1'b0;
                    wbwe_d      = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else if (bus.dwbm_ack_i) begin
                    cyc_d       = 1'b0;
                    wbwe_d      = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = we_q ? 32'h0 : al_rdata;
                end else if (timeout_hit) begin
                    cyc_d       = 1'b0;
                    wbwe_d      = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else if (cnt_q != '1) begin
                    // Saturate so a disabled timeout never wraps.
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            off_q       <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            addr_q      <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            cyc_q       <= 1'b0;
            wbwe_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_mis_q   <= 1'b0;
        end else begin
            off_q       <= off_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            cyc_q       <= cyc_d;
            wbwe_q      <= wbwe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_mis_q   <= rsp_mis_d;
        end
    end

    // Ready is gated by reset so every output reads 0 while rst_ni is low.
    assign bus.ls_ready_o       = (state_q == ST_IDLE) && rst_ni;
    assign bus.rsp_valid_o      = rsp_valid_q;
    assign bus.rsp_rdata_o      = rsp_rdata_q;
    assign bus.rsp_err_o        = rsp_err_q;
    assign bus.rsp_misaligned_o = rsp_mis_q;
    assign bus.dwbm_addr_o      = addr_q;
    assign bus.dwbm_dat_o       = dat_q;
    assign bus.dwbm_sel_o       = sel_q;
    assign bus.dwbm_cyc_o       = cyc_q;
    assign bus.dwbm_stb_o       = cyc_q;
    assign bus.dwbm_we_o        = wbwe_q;

endmodule

// File: tb/tb_wb_dbus_master.sv
module tb_wb_dbus_master;

    localparam int TO = 4;
    localparam int M_ACK = 0, M_ERR = 1, M_BOTH = 2, M_NONE = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    wb_dbus_master_if bus ();

    wb_dbus_master #(.TIMEOUT(TO), .BASE_ADDR(32'h0)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: what a request should produce, from the access rules.
    task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                          input int mode, input int wait_n, input logic [31:0] sdata);
        int          off, exp_cyc, exp_lat, cyc_cnt;
        logic        mis, ill, term, exp_err, got;
        logic [31:0] exp_sel, exp_dat, exp_rd, v;

        off  = int'(addr % 4);
        mis  = (size == 2'd1 && (addr % 2) != 0) || (size == 2'd2 && off != 0);
        ill  = (size == 2'd3);
        exp_rd = 0;
        case (size)
            2'd0:    begin exp_sel = 32'(1 << off);           exp_dat = (wdata & 32'hFF) * 32'h0101_0101; end
            2'd1:    begin exp_sel = (off >= 2) ? 32'hC : 32'h3; exp_dat = (wdata & 32'hFFFF) * 32'h0001_0001; end
            default: begin exp_sel = 32'hF;                    exp_dat = wdata; end
        endcase
        if (mis || ill) begin
            exp_cyc = 0; exp_lat = 1; exp_err = ill;
        end else begin
            term    = (mode != M_NONE) && (wait_n < TO);
            exp_cyc = term ? wait_n + 1 : TO;
            exp_lat = exp_cyc + 1;
            exp_err = !term || (mode != M_ACK);
            if (!we && term && mode == M_ACK) begin
                v = sdata / (32'd1 << (8 * off));
                if (size == 2'd0) begin
                    v = v % 256;
                    if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
                end else if (size == 2'd1) begin
                    v = v % 65536;
                    if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
                end
                exp_rd = v;
            end
        end

        @(negedge clk);
        bus.ls_valid_i    = 1'b1;
        bus.ls_we_i       = we;
        bus.ls_addr_i     = addr;
        bus.ls_wdata_i    = wdata;
        bus.ls_size_i     = size;
        bus.ls_unsigned_i = uns;
        chk({tag, " ready"}, 32'(bus.ls_ready_o), 32'd1);
        @(posedge clk);
        #1;
        bus.ls_valid_i    = 1'b0;
        bus.ls_we_i       = 1'($urandom);
        bus.ls_addr_i     = $urandom;
        bus.ls_wdata_i    = $urandom;
        bus.ls_size_i     = 2'($urandom);
        bus.ls_unsigned_i = 1'($urandom);

        got = 1'b0;
        cyc_cnt = 0;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(negedge clk);
            if (bus.dwbm_cyc_o) begin
                cyc_cnt++;
                chk({tag, " stb"},  32'(bus.dwbm_stb_o), 32'd1);
                chk({tag, " addr"}, bus.dwbm_addr_o, addr & 32'hFFFF_FFFC);
                chk({tag, " sel"},  32'(bus.dwbm_sel_o), exp_sel);
                chk({tag, " we"},   32'(bus.dwbm_we_o), 32'(we));
                if (we) chk({tag, " dat_o"}, bus.dwbm_dat_o, exp_dat);
                bus.dwbm_ack_i = (mode == M_ACK || mode == M_BOTH) && (cyc_cnt - 1 == wait_n);
                bus.dwbm_err_i = (mode == M_ERR || mode == M_BOTH) && (cyc_cnt - 1 == wait_n);
                bus.dwbm_dat_i = (cyc_cnt - 1 == wait_n) ? sdata : $urandom;
            end else begin
                // Stray handshakes outside a cycle must be ignored.
                bus.dwbm_ack_i = 1'($urandom);
                bus.dwbm_err_i = 1'($urandom);
                bus.dwbm_dat_i = $urandom;
            end
            if (bus.rsp_valid_o) begin
                got = 1'b1;
                chk({tag, " latency"}, 32'(c), 32'(exp_lat));
                chk({tag, " cyc_cycles"}, 32'(cyc_cnt), 32'(exp_cyc));
                chk({tag, " rdata"}, bus.rsp_rdata_o, exp_rd);
                chk({tag, " err"}, 32'(bus.rsp_err_o), 32'(exp_err));
                chk({tag, " misaligned"}, 32'(bus.rsp_misaligned_o), 32'(mis));
                chk({tag, " ready_busy"}, 32'(bus.ls_ready_o), 32'd0);
            end
        end
        if (!got) chk({tag, " rsp_seen"}, 32'd0, 32'd1);
        @(negedge clk);
        chk({tag, " rsp_pulse"}, 32'(bus.rsp_valid_o), 32'd0);
        chk({tag, " ready_after"}, 32'(bus.ls_ready_o), 32'd1);
    endtask

    initial begin
        logic stray;
        bus.ls_valid_i = 1'b0; bus.ls_we_i = 1'b0; bus.ls_addr_i = '0; bus.ls_wdata_i = '0;
        bus.ls_size_i = '0; bus.ls_unsigned_i = 1'b0;
        bus.dwbm_dat_i = '0; bus.dwbm_ack_i = 1'b0; bus.dwbm_err_i = 1'b0;
        #12;
        chk("rst cyc",   32'(bus.dwbm_cyc_o), 0);
        chk("rst stb",   32'(bus.dwbm_stb_o), 0);
        chk("rst rsp",   32'(bus.rsp_valid_o), 0);
        chk("rst ready", 32'(bus.ls_ready_o), 0);
        chk("rst sel",   32'(bus.dwbm_sel_o), 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_req("t1 lw",       1'b0, 32'h100, 32'h0,        2'd2, 1'b0, M_ACK, 0, 32'hDEAD_BEEF);
        do_req("t2 lb",       1'b0, 32'h103, 32'h0,        2'd0, 1'b0, M_ACK, 0, 32'h8000_0000);
        do_req("t2 lbu",      1'b0, 32'h103, 32'h0,        2'd0, 1'b1, M_ACK, 0, 32'h8000_0000);
        do_req("t3 sh",       1'b1, 32'h102, 32'h1234_ABCD, 2'd1, 1'b0, M_ACK, 0, 32'h5555_5555);
        do_req("t4 lw mis",   1'b0, 32'h101, 32'h0,        2'd2, 1'b0, M_ACK, 0, 32'h1);
        do_req("ill size",    1'b0, 32'h104, 32'h0,        2'd3, 1'b0, M_ACK, 0, 32'h1);
        do_req("t5 timeout",  1'b0, 32'h108, 32'h0,        2'd2, 1'b0, M_NONE, 0, 32'h1);
        do_req("t5 ack+err",  1'b0, 32'h108, 32'h0,        2'd2, 1'b0, M_BOTH, 1, 32'h1);
        do_req("last wait",   1'b0, 32'h10A, 32'h0,        2'd1, 1'b0, M_ACK, TO - 1, 32'h9876_0000);

        for (int i = 0; i < 200; i++) begin
            int m, r;
            r = int'($urandom_range(0, 9));
            m = (r < 6) ? M_ACK : (r < 8) ? M_ERR : (r < 9) ? M_BOTH : M_NONE;
            do_req("rand", 1'($urandom), $urandom, $urandom,
                   ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                   1'($urandom), m, int'($urandom_range(0, 5)), $urandom);
        end

        // Reset in the middle of a bus cycle.
        @(negedge clk);
        bus.ls_valid_i = 1'b1; bus.ls_we_i = 1'b0; bus.ls_addr_i = 32'h200; bus.ls_size_i = 2'd2;
        @(posedge clk);
        #1;
        bus.ls_valid_i = 1'b0; bus.dwbm_ack_i = 1'b0; bus.dwbm_err_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t6 cyc_pre", 32'(bus.dwbm_cyc_o), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6 cyc",   32'(bus.dwbm_cyc_o), 0);
        chk("t6 stb",   32'(bus.dwbm_stb_o), 0);
        chk("t6 rsp",   32'(bus.rsp_valid_o), 0);
        chk("t6 ready", 32'(bus.ls_ready_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            stray = stray | bus.rsp_valid_o | bus.dwbm_cyc_o;
        end
        chk("t6 no_spurious", 32'(stray), 0);
        chk("t6 ready_after", 32'(bus.ls_ready_o), 1);
        do_req("t6 post", 1'b0, 32'h300, 32'h0, 2'd0, 1'b1, M_ACK, 2, 32'h00AB_0000 + 32'hC3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wb_dbus_master.md
Name: wb_dbus_master

Overview:
Wishbone classic-cycle initiator for the core's load/store path. It is the bus-master counterpart of the dual-port Wishbone RAM's data port. It accepts one load/store request at a time from the pipeline and generates byte selects, write-data lane replication and an aligned address. It runs the Wishbone cycle with a timeout, then returns aligned, sign- or zero-extended read data plus error flags.

Parameters:
TIMEOUT, 255, maximum number of cycles to wait for ack/err once cyc/stb are high; 0 disables the timeout.
BASE_ADDR, 32'h0000_0000, unused by the datapath; reserved for an address-range check in a later revision.

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous reset, active-low
ls_valid_i  in  1  request valid
ls_ready_o  out  1  request accepted when ls_valid_i & ls_ready_o
ls_we_i  in  1  1 = store, 0 = load
ls_addr_i  in  32  byte address
ls_wdata_i  in  32  store data, right-aligned
ls_size_i  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
ls_unsigned_i  in  1  zero-extend loads when 1
rsp_valid_o  out  1  one-cycle response pulse
rsp_rdata_o  out  32  extended load data; 0 for stores and errors
rsp_err_o  out  1  bus error, timeout or illegal size
rsp_misaligned_o  out  1  address not aligned to size
dwbm_addr_o  out  32  {addr[31:2], 2'b00}
dwbm_dat_o  out  32  replicated write data
dwbm_sel_o  out  4  byte lane selects
dwbm_cyc_o  out  1  Wishbone cycle
dwbm_stb_o  out  1  Wishbone strobe
dwbm_we_o  out  1  Wishbone write enable
dwbm_dat_i  in  32  read data
dwbm_ack_i  in  1  transfer acknowledge; may be combinational
dwbm_err_i  in  1  bus error

Behaviour:
- States: IDLE, BUS, RESP.
- Reset (asynchronous, rst_ni=0):
  - state becomes IDLE; all outputs 0.
  - If reset arrives mid-cycle, cyc/stb drop immediately and no response is issued.
- ls_ready_o = (state == IDLE).
- IDLE, on accept:
  - Latch addr[1:0], size, unsigned and we.
  - Misaligned (half with addr[0]=1, or word with addr[1:0]!=0): go to RESP with misaligned=1. No bus cycle.
  - size == 11: go to RESP with err=1. No bus cycle.
  - Otherwise: register dwbm_addr_o, dwbm_dat_o, dwbm_sel_o and dwbm_we_o; assert cyc=stb=1; clear the timeout counter; go to BUS.
- Lane rules:
  - byte: sel = 4'b0001 << addr[1:0]; dat = {4{wdata[7:0]}}.
  - half: sel = addr[1] ? 4'b1100 : 4'b0011; dat = {2{wdata[15:0]}}.
  - word: sel = 4'b1111; dat = wdata.
- BUS: cyc/stb/we/addr/sel/dat are held stable every cycle until termination.
  - err_i=1 (err has priority over a simultaneous ack): drop cyc/stb; go to RESP with err=1.
  - ack_i=1: drop cyc/stb; capture dwbm_dat_i >> (8*addr[1:0]) and extend per size/unsigned; go to RESP.
  - Otherwise increment the counter. When TIMEOUT != 0 and the counter reaches TIMEOUT-1 with no termination: drop cyc/stb; go to RESP with err=1.
  - Counter width is $clog2(TIMEOUT+1); it never wraps.
- RESP:
  - rsp_valid_o=1 for exactly one cycle; rsp_* outputs are registered and valid only in this cycle.
  - Go to IDLE.
  - rsp_rdata_o is 0 for stores, errors and misaligned requests.
- Latency, zero-wait slave: accept at cycle 0; cyc/stb high in cycle 1; ack in cycle 1; rsp_valid in cycle 2; next accept in cycle 3.
- Latency, misaligned or illegal request: rsp_valid in cycle 1.
- Inputs presented while not in IDLE are ignored.
- ack_i or err_i arriving while cyc=0 is ignored.

Decomposition:
- Shared package wb_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - state enum.
  - function sel_gen(size, addr[1:0]).
- Sub-module lsu_align: purely combinational.
  - Store lane replication and sel generation.
  - Load shift and extension.
  - Misalignment detect.
- The FSM, timeout counter and registers stay in the top module.

Test Plan:
1. Load word, addr 0x100, slave returns 0xDEADBEEF with a combinational ack -> sel=1111, cyc high for 1 cycle, rsp_valid in cycle 2, rdata 0xDEADBEEF, err=0.
2. Signed byte load, addr 0x103, dat_i 0x80_00_00_00 -> sel=1000, rdata 0xFFFFFF80. Repeat with unsigned=1 -> rdata 0x00000080.
3. Half store, addr 0x102, wdata 0x1234ABCD -> dat_o 0xABCDABCD, sel=1100, we=1, rsp rdata 0.
4. Word load at addr 0x101 -> no cyc ever asserted; rsp_valid at cycle 1 with misaligned=1.
5. Slave never acks, TIMEOUT=4 -> cyc high exactly 4 cycles, then rsp err=1. In a separate run, ack and err asserted together -> err=1.
6. Assert rst_ni low while cyc=1 -> cyc/stb/rsp_valid go 0 asynchronously; after release, ls_ready_o=1 and no spurious rsp_valid.
